// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared types, blank pattern and hex-to-segment encoding table
//               for the seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Active-low {CA,CB,CC,CD,CE,CF,CG}
    function automatic seg_t hex_to_sseg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_hex_encoder.sv
`default_nettype none
// ============================================================================
// Module      : sseg_hex_encoder
// Description : Combinational nibble to active-low seven-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_hex_encoder
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_sseg(nibble);

endmodule
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_ctrl
// Description : 8-digit common-anode scan controller with per-slot blanking.
//               Optional SSEG_LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_blank    = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    state_t           state_q, state_d;
    logic             run_q, run_d;
    logic [31:0]      pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [7:0]       pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic [7:0]       pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [7:0]       anodes_q, anodes_d;
    logic [6:0]       segments_q, segments_d;
    logic             dp_q, dp_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_bound;
    logic             digit_on;
    logic             dp_ok;
    logic [6:0]       enc_seg;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic [2:0] msd_q, msd_d;

    function automatic logic [2:0] highest_nonzero(input logic [31:0] v);
        logic [2:0] m;
        m = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] != 4'h0) m = 3'(i);
        end
        return m;
    endfunction
`endif

    sseg_hex_encoder u_enc (
        .nibble (act_val_d[{idx_d, 2'b00} +: 4]),
        .seg    (enc_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            state_q       <= BLANK;
            run_q         <= 1'b0;
            pend_val_q    <= '0;
            pend_en_q     <= '0;
            pend_dp_q     <= '0;
            act_val_q     <= '0;
            act_en_q      <= '0;
            act_dp_q      <= '0;
            anodes_q      <= 8'hFF;
            segments_q    <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            msd_q         <= 3'd0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            run_q         <= run_d;
            pend_val_q    <= pend_val_d;
            pend_en_q     <= pend_en_d;
            pend_dp_q     <= pend_dp_d;
            act_val_q     <= act_val_d;
            act_en_q      <= act_en_d;
            act_dp_q      <= act_dp_d;
            anodes_q      <= anodes_d;
            segments_q    <= segments_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            msd_q         <= msd_d;
`endif
        end
    end

    // run_q low means the scan is (re)starting: the next enabled cycle is slot 0, cnt 0.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        state_d     = state_q;
        run_d       = run_q;
        frame_bound = 1'b0;
        pend_val_d  = pend_val_q;
        pend_en_d   = pend_en_q;
        pend_dp_d   = pend_dp_q;
        act_val_d   = act_val_q;
        act_en_d    = act_en_q;
        act_dp_d    = act_dp_q;

        if (wr_en) begin
            pend_val_d = value;
            pend_en_d  = digit_en;
            pend_dp_d  = dp_mask;
        end

        if (!en) begin
            cnt_d   = '0;
            idx_d   = 3'd0;
            state_d = BLANK;
            run_d   = 1'b0;
        end else if (!run_q) begin
            cnt_d       = '0;
            idx_d       = 3'd0;
            state_d     = BLANK;
            run_d       = 1'b1;
            frame_bound = 1'b1;
        end else if (cnt_q == c_cnt_last) begin
            cnt_d       = '0;
            idx_d       = idx_q + 3'd1;
            state_d     = BLANK;
            frame_bound = (idx_q == 3'd7);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == BLANK && cnt_d >= c_blank) state_d = DRIVE;
        end

        // Active takes the pre-edge pending copy, so a write on the boundary waits a frame.
        if (frame_bound) begin
            act_val_d = pend_val_q;
            act_en_d  = pend_en_q;
            act_dp_d  = pend_dp_q;
        end
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        msd_d = msd_q;
        if (frame_bound) msd_d = highest_nonzero(pend_val_q);
    end
`endif

    always_comb begin
        anodes_d      = 8'hFF;
        segments_d    = SEG_BLANK;
        dp_d          = 1'b1;
        frame_start_d = frame_bound;
        dp_ok         = 1'b1;
        digit_on      = act_en_d[idx_d];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        dp_ok    = (idx_d <= msd_d);
        digit_on = digit_on & dp_ok;
`endif
        if (state_d == DRIVE) begin
            anodes_d   = digit_on ? ~(8'b1 << idx_d) : 8'hFF;
            segments_d = enc_seg;
            dp_d       = ~(act_dp_d[idx_d] & dp_ok);
        end
    end

    assign anodes      = anodes_q;
    assign segments    = segments_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_ctrl
// Description : Self-checking bench for sseg_scan_ctrl (SCAN_DIV=10, BLANK_CYCLES=2)
//               decoding the pins frame by frame against a queued expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, wr_en;
    logic [31:0] value;
    logic [7:0]  digit_en, dp_mask;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        dp, frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] val;
        logic [7:0]  en;
        logic [7:0]  dp;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.SCAN_DIV(10), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .value       (value),
        .digit_en    (digit_en),
        .dp_mask     (dp_mask),
        .anodes      (anodes),
        .segments    (segments),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [31:0] v, input logic [7:0] de, input logic [7:0] dm);
        exp_t r;
        logic [7:0] elig;
        int msd;
        elig = 8'hFF;
        msd  = 0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) msd = i;
        elig = 8'h00;
        for (int i = 0; i <= msd; i++) elig[i] = 1'b1;
`endif
        r.en  = de & elig;
        r.dp  = dm & elig;
        r.val = '0;
        for (int i = 0; i < 8; i++) if (r.en[i]) r.val[4*i +: 4] = v[4*i +: 4];
        return r;
    endfunction

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0_0000;
        for (int i = 0; i < 16; i++) if (seg_tab[i] == s) r = {1'b1, 4'(i)};
        return r;
    endfunction

    task automatic write_value(input logic [31:0] v, input logic [7:0] de, input logic [7:0] dm);
        value = v; digit_en = de; dp_mask = dm; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Entered on the negedge where frame_start is high; returns on the last cycle of slot 7.
    task automatic observe_frame(output logic [31:0] val, output logic [7:0] en_seen,
                                 output logic [7:0] dp_seen, output int err);
        int         slot, c;
        logic [7:0] one_hot;
        logic [4:0] dec;
        val = '0; en_seen = '0; dp_seen = '0; err = 0;
        for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge clk);
            slot    = i / 10;
            c       = i % 10;
            one_hot = 8'b1 << slot;
            if (frame_start !== (i == 0)) err++;
            if (c < 2) begin
                if (anodes !== 8'hFF || segments !== 7'h7F || dp !== 1'b1) err++;
            end else begin
                if (anodes !== 8'hFF) begin
                    dec = decode(segments);
                    if (anodes !== ~one_hot || !dec[4]) err++;
                    else begin
                        en_seen[slot]     = 1'b1;
                        val[4*slot +: 4]  = dec[3:0];
                    end
                end
                if (dp === 1'b0) dp_seen[slot] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; value = '0; digit_en = '0; dp_mask = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (anodes !== 8'hFF)  begin n_fail++; $display("FAIL rst_anodes: got %h want ff", anodes); end
        n_checks++; if (segments !== 7'h7F) begin n_fail++; $display("FAIL rst_segments: got %h want 7f", segments); end
        n_checks++; if (dp !== 1'b1)       begin n_fail++; $display("FAIL rst_dp: got %b want 1", dp); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
        rst_n = 1'b1; en = 1'b1;
        wait_frame_start(ok);
        @(negedge clk);
        write_value(32'h0000_F000, 8'hFF, 8'h00);
        wait_frame_start(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_first_frame: got timeout want frame_start"); end
        repeat (35) @(negedge clk);
        n_checks++; if (anodes !== 8'hF7) begin n_fail++; $display("FAIL slot3_drive: got %h want f7", anodes); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (anodes !== 8'hFF || segments !== 7'h7F || dp !== 1'b1) begin
            n_fail++; $display("FAIL async_rst: got an=%h seg=%h dp=%b want ff 7f 1", anodes, segments, dp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (frame_start !== 1'b1 || anodes !== 8'hFF) begin
            n_fail++; $display("FAIL rst_release: got fs=%b an=%h want 1 ff", frame_start, anodes);
        end
    endtask

    task automatic test_value();
        bit ok;
        logic [31:0] v; logic [7:0] e, d; int err; exp_t ex;
        repeat (5) @(negedge clk);
        write_value(32'h0123_4567, 8'hFF, 8'h00);
        sb.push_back(model(32'h0123_4567, 8'hFF, 8'h00));
        wait_frame_start(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL value_wait: got timeout want frame_start"); end
        observe_frame(v, e, d, err);
        ex = sb.pop_front();
        n_checks++;
        if (v !== ex.val || e !== ex.en || d !== ex.dp || err != 0) begin
            n_fail++; $display("FAIL value_frame: got val=%h en=%h dp=%h err=%0d want val=%h en=%h dp=%h err=0",
                               v, e, d, err, ex.val, ex.en, ex.dp);
        end
    endtask

    task automatic test_boundary_write();
        logic [31:0] v; logic [7:0] e, d; int err; exp_t ex;
        sb.push_back(model(32'h0123_4567, 8'hFF, 8'h00));
        sb.push_back(model(32'hAAAA_AAAA, 8'hFF, 8'h00));
        write_value(32'hAAAA_AAAA, 8'hFF, 8'h00);
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL bnd_fs: got %b want 1", frame_start); end
        for (int f = 0; f < 2; f++) begin
            if (f > 0) @(negedge clk);
            observe_frame(v, e, d, err);
            ex = sb.pop_front();
            n_checks++;
            if (v !== ex.val || e !== ex.en || d !== ex.dp || err != 0) begin
                n_fail++; $display("FAIL bnd_frame%0d: got val=%h en=%h dp=%h err=%0d want val=%h en=%h dp=%h err=0",
                                   f, v, e, d, err, ex.val, ex.en, ex.dp);
            end
        end
    endtask

    task automatic test_digit_mask(input logic [31:0] val_in, input logic [7:0] de,
                                   input logic [7:0] dm, input int frames);
        bit ok;
        logic [31:0] v; logic [7:0] e, d; int err; exp_t ex;
        repeat (5) @(negedge clk);
        write_value(val_in, de, dm);
        for (int f = 0; f < frames; f++) sb.push_back(model(val_in, de, dm));
        wait_frame_start(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mask_wait: got timeout want frame_start"); end
        for (int f = 0; f < frames; f++) begin
            if (f > 0) @(negedge clk);
            observe_frame(v, e, d, err);
            ex = sb.pop_front();
            n_checks++;
            if (v !== ex.val || e !== ex.en || d !== ex.dp || err != 0) begin
                n_fail++; $display("FAIL mask_%h_f%0d: got val=%h en=%h dp=%h err=%0d want val=%h en=%h dp=%h err=0",
                                   val_in, f, v, e, d, err, ex.val, ex.en, ex.dp);
            end
        end
    endtask

    task automatic test_enable();
        logic [31:0] v; logic [7:0] e, d; int err; exp_t ex;
        logic [7:0] exp_an;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        exp_an = 8'hFF;
`else
        exp_an = 8'hEF;
`endif
        @(negedge clk);
        repeat (46) @(negedge clk);
        n_checks++; if (anodes !== exp_an) begin n_fail++; $display("FAIL en_pre: got %h want %h", anodes, exp_an); end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (anodes !== 8'hFF || segments !== 7'h7F || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL en_low: got an=%h seg=%h fs=%b want ff 7f 0", anodes, segments, frame_start);
        end
        write_value(32'h0000_1234, 8'hFF, 8'h00);
        sb.push_back(model(32'h0000_1234, 8'hFF, 8'h00));
        repeat (20) @(negedge clk);
        n_checks++; if (anodes !== 8'hFF) begin n_fail++; $display("FAIL en_dark: got %h want ff", anodes); end
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL en_rise_fs: got %b want 1", frame_start); end
        observe_frame(v, e, d, err);
        ex = sb.pop_front();
        n_checks++;
        if (v !== ex.val || e !== ex.en || d !== ex.dp || err != 0) begin
            n_fail++; $display("FAIL en_frame: got val=%h en=%h dp=%h err=%0d want val=%h en=%h dp=%h err=0",
                               v, e, d, err, ex.val, ex.en, ex.dp);
        end
    endtask

    initial begin
        test_reset();
        test_value();
        test_boundary_write();
        test_digit_mask(32'h89AB_CDEF, 8'h0F, 8'h01, 3);
        test_digit_mask(32'h0000_0040, 8'hFF, 8'h00, 1);
        test_enable();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
